// File: rtl/gbf_act_writer_pkg.sv
// Shared definitions for the compressing activation writer.
// Holds the default block geometry, the GBF address width, the valid-num
// width (wide enough to hold a count equal to the full block depth) and the
// writer state encoding.
package gbf_act_writer_pkg;

    localparam int ACT_DATA_WIDTH   = 8;
    localparam int ACT_BLOCK_DEPTH  = 32;
    localparam int GBFACT_ADDRWIDTH = 12;
    localparam int ACT_IDX_WIDTH    = $clog2(ACT_BLOCK_DEPTH);
    localparam int ACT_VN_WIDTH     = ACT_IDX_WIDTH + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRHDR = 2'd1,
        ST_WRDAT = 2'd2,
        ST_DONE  = 2'd3
    } wr_state_e;

endpackage

// File: rtl/gbf_act_writer_lsb.sv
// act_lsb_scan: combinational lowest-set-bit finder over the remaining
// nonzero mask.
//   mask   in   DEPTH  remaining nonzero mask
//   onehot out  DEPTH  one-hot lowest set bit (all zero if mask is empty)
//   idx    out  IDX_W  index of the lowest set bit (0 if mask is empty)
//   last   out  1      exactly one bit of mask is set
module act_lsb_scan
    import gbf_act_writer_pkg::*;
#(
    parameter int DEPTH = ACT_BLOCK_DEPTH,
    parameter int IDX_W = ACT_IDX_WIDTH
) (
    input  logic [DEPTH-1:0] mask,
    output logic [DEPTH-1:0] onehot,
    output logic [IDX_W-1:0] idx,
    output logic             last
);

    localparam logic [DEPTH-1:0] MASK_ONE  = {{(DEPTH-1){1'b0}}, 1'b1};
    localparam logic [DEPTH-1:0] MASK_ZERO = {DEPTH{1'b0}};

    // Isolate the lowest set bit, encode it, and detect a single remaining bit.
    always_comb begin
        onehot = mask & (~mask + MASK_ONE);
        idx    = {IDX_W{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            idx = idx | ({IDX_W{onehot[i]}} & IDX_W'(i));
        end
        // Clearing the lowest bit leaves nothing exactly when one bit was set.
        last = (mask != MASK_ZERO) && ((mask & (mask - MASK_ONE)) == MASK_ZERO);
    end

endmodule

// File: rtl/gbf_act_writer.sv
// gbf_act_writer: compresses one dense activation block into
//   - a nonzero-flag bitmap   -> flag GBF      (GBFFLGACT_*)
//   - the nonzero count       -> valid-num GBF (GBFVNACT_*)
//   - the nonzero values only, ascending element order -> act GBF (GBFACT_*)
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   CMPACT_Clr                      layer start, clears write addresses (IDLE only)
//   CMPACT_ValAct / CMPACT_RdyAct   dense block handshake (Rdy is combinational)
//   CMPACT_Act                      dense block, element i at [i*DATA_WIDTH +: DATA_WIDTH]
//   CMPACT_Fnh                      one-cycle pulse when a block is fully written
//   GBF*_Full / EnWr / AddrWr / DatWr   the three GBF write ports
// Write enables are decoded from the registered state gated by the matching
// Full input; addresses and data come straight from registers.
module gbf_act_writer
    import gbf_act_writer_pkg::*;
#(
    parameter int DATA_WIDTH  = ACT_DATA_WIDTH,
    parameter int BLOCK_DEPTH = ACT_BLOCK_DEPTH,
    parameter int ADDR_WIDTH  = GBFACT_ADDRWIDTH,
    parameter int VN_WIDTH    = ACT_VN_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          CMPACT_Clr,
    input  logic                          CMPACT_ValAct,
    output logic                          CMPACT_RdyAct,
    input  logic [DATA_WIDTH*BLOCK_DEPTH-1:0] CMPACT_Act,
    output logic                          CMPACT_Fnh,
    input  logic                          GBFFLGACT_Full,
    output logic                          GBFFLGACT_EnWr,
    output logic [ADDR_WIDTH-1:0]         GBFFLGACT_AddrWr,
    output logic [BLOCK_DEPTH-1:0]        GBFFLGACT_DatWr,
    input  logic                          GBFVNACT_Full,
    output logic                          GBFVNACT_EnWr,
    output logic [ADDR_WIDTH-1:0]         GBFVNACT_AddrWr,
    output logic [VN_WIDTH-1:0]           GBFVNACT_DatWr,
    input  logic                          GBFACT_Full,
    output logic                          GBFACT_EnWr,
    output logic [ADDR_WIDTH-1:0]         GBFACT_AddrWr,
    output logic [DATA_WIDTH-1:0]         GBFACT_DatWr
);

    localparam int IDX_WIDTH = $clog2(BLOCK_DEPTH);
    localparam int BLK_WIDTH = DATA_WIDTH * BLOCK_DEPTH;

    localparam logic [ADDR_WIDTH-1:0]  ADDR_ZERO  = {ADDR_WIDTH{1'b0}};
    localparam logic [ADDR_WIDTH-1:0]  ADDR_ONE   = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [DATA_WIDTH-1:0]  DATA_ZERO  = {DATA_WIDTH{1'b0}};
    localparam logic [BLOCK_DEPTH-1:0] MASK_ZERO  = {BLOCK_DEPTH{1'b0}};
    localparam logic [VN_WIDTH-1:0]    COUNT_ZERO = {VN_WIDTH{1'b0}};
    localparam logic [BLK_WIDTH-1:0]   BLK_ZERO   = {BLK_WIDTH{1'b0}};

    wr_state_e                state_r;
    wr_state_e                state_n_s;
    logic [BLK_WIDTH-1:0]     block_r;
    logic [BLOCK_DEPTH-1:0]   mask_r;
    logic [VN_WIDTH-1:0]      count_r;
    logic [ADDR_WIDTH-1:0]    flg_addr_r;
    logic [ADDR_WIDTH-1:0]    vn_addr_r;
    logic [ADDR_WIDTH-1:0]    act_addr_r;

    logic [BLOCK_DEPTH-1:0]   mask_s;
    logic [VN_WIDTH-1:0]      count_s;
    logic                     accept_s;
    logic                     hdr_wr_s;
    logic                     act_wr_s;
    logic                     fnh_s;
    logic [BLOCK_DEPTH-1:0]   onehot_s;
    logic [IDX_WIDTH-1:0]     idx_s;
    logic                     last_s;

    act_lsb_scan #(
        .DEPTH (BLOCK_DEPTH),
        .IDX_W (IDX_WIDTH)
    ) u_lsb_scan (
        .mask   (mask_r),
        .onehot (onehot_s),
        .idx    (idx_s),
        .last   (last_s)
    );

    // Nonzero mask and its population count for the block on the input bus.
    always_comb begin
        mask_s  = MASK_ZERO;
        count_s = COUNT_ZERO;
        for (int i = 0; i < BLOCK_DEPTH; i++) begin
            mask_s[i] = (CMPACT_Act[i*DATA_WIDTH +: DATA_WIDTH] != DATA_ZERO);
            count_s   = count_s + VN_WIDTH'(mask_s[i]);
        end
    end

    // Clr blocks acceptance in the same cycle, so it wins over Val.
    assign CMPACT_RdyAct = (state_r == ST_IDLE) && !CMPACT_Clr;
    assign accept_s      = CMPACT_ValAct && CMPACT_RdyAct;

    // Writer state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_n_s;
        end
    end

    // Next-state and write-enable decode; a Full input stalls its port in place.
    always_comb begin
        state_n_s = state_r;
        hdr_wr_s  = 1'b0;
        act_wr_s  = 1'b0;
        fnh_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_n_s = ST_WRHDR;
                end else begin
                    state_n_s = ST_IDLE;
                end
            end
            ST_WRHDR: begin
                if (!GBFFLGACT_Full && !GBFVNACT_Full) begin
                    hdr_wr_s  = 1'b1;
                    state_n_s = (count_r != COUNT_ZERO) ? ST_WRDAT : ST_DONE;
                end else begin
                    state_n_s = ST_WRHDR;
                end
            end
            ST_WRDAT: begin
                if (!GBFACT_Full) begin
                    act_wr_s  = 1'b1;
                    state_n_s = last_s ? ST_DONE : ST_WRDAT;
                end else begin
                    state_n_s = ST_WRDAT;
                end
            end
            ST_DONE: begin
                fnh_s     = 1'b1;
                state_n_s = ST_IDLE;
            end
            default: begin
                state_n_s = ST_IDLE;
            end
        endcase
    end

    // Block capture, mask consumption and the three write-address counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            block_r    <= BLK_ZERO;
            mask_r     <= MASK_ZERO;
            count_r    <= COUNT_ZERO;
            flg_addr_r <= ADDR_ZERO;
            vn_addr_r  <= ADDR_ZERO;
            act_addr_r <= ADDR_ZERO;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (CMPACT_Clr) begin
                        flg_addr_r <= ADDR_ZERO;
                        vn_addr_r  <= ADDR_ZERO;
                        act_addr_r <= ADDR_ZERO;
                    end else if (accept_s) begin
                        block_r <= CMPACT_Act;
                        mask_r  <= mask_s;
                        count_r <= count_s;
                    end else begin
                        mask_r <= mask_r;
                    end
                end
                ST_WRHDR: begin
                    if (hdr_wr_s) begin
                        flg_addr_r <= flg_addr_r + ADDR_ONE;
                        vn_addr_r  <= vn_addr_r + ADDR_ONE;
                    end else begin
                        flg_addr_r <= flg_addr_r;
                    end
                end
                ST_WRDAT: begin
                    if (act_wr_s) begin
                        mask_r     <= mask_r & ~onehot_s;
                        act_addr_r <= act_addr_r + ADDR_ONE;
                    end else begin
                        mask_r <= mask_r;
                    end
                end
                ST_DONE: begin
                    mask_r <= mask_r;
                end
                default: begin
                    mask_r <= mask_r;
                end
            endcase
        end
    end

    assign GBFFLGACT_EnWr   = hdr_wr_s;
    assign GBFFLGACT_AddrWr = flg_addr_r;
    assign GBFFLGACT_DatWr  = mask_r;

    assign GBFVNACT_EnWr    = hdr_wr_s;
    assign GBFVNACT_AddrWr  = vn_addr_r;
    assign GBFVNACT_DatWr   = count_r;

    assign GBFACT_EnWr      = act_wr_s;
    assign GBFACT_AddrWr    = act_addr_r;
    assign GBFACT_DatWr     = block_r[int'(idx_s)*DATA_WIDTH +: DATA_WIDTH];

    assign CMPACT_Fnh       = fnh_s;

endmodule

// File: doc/gbf_act_writer.md
Name: gbf_act_writer

Overview:
- Compressing writer for the activation global buffers: the producer-side counterpart of the activation distributor/unpacker.
- Accepts one dense block of BLOCK_DEPTH activations. Writes three things:
  - the nonzero-flag bitmap to the flag GBF,
  - the nonzero count to the valid-num GBF,
  - the nonzero values only, in ascending element order, to the activation GBF.
- Sits between the PE-array output/pooling path and the three GBF write ports.
- Its output format is exactly what the distributor consumes: flag bit i set means element i is nonzero, and packed data is in ascending i.

Parameters:
- DATA_WIDTH, 8, activation width.
- BLOCK_DEPTH, 32, elements per block. Must be a power of 2.
- ADDR_WIDTH, 12, GBF address width, shared by all three buffers.
- VN_WIDTH, 6, valid-num width, equal to clog2(BLOCK_DEPTH)+1 so that a count of BLOCK_DEPTH fits.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset.
- CMPACT_Clr  in  1  layer start; clears all write addresses.
- CMPACT_ValAct  in  1  dense block valid.
- CMPACT_RdyAct  out  1  block accepted when Val&&Rdy.
- CMPACT_Act  in  DATA_WIDTH*BLOCK_DEPTH  dense block; element i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- CMPACT_Fnh  out  1  one-cycle pulse when a block is fully written.
- GBFFLGACT_Full  in  1  flag GBF cannot accept a write.
- GBFFLGACT_EnWr  out  1  flag GBF write enable.
- GBFFLGACT_AddrWr  out  ADDR_WIDTH  flag GBF write address.
- GBFFLGACT_DatWr  out  BLOCK_DEPTH  flag bitmap.
- GBFVNACT_Full  in  1  valid-num GBF cannot accept a write.
- GBFVNACT_EnWr  out  1  valid-num GBF write enable.
- GBFVNACT_AddrWr  out  ADDR_WIDTH  valid-num GBF write address.
- GBFVNACT_DatWr  out  VN_WIDTH  nonzero count.
- GBFACT_Full  in  1  activation GBF cannot accept a write.
- GBFACT_EnWr  out  1  activation GBF write enable.
- GBFACT_AddrWr  out  ADDR_WIDTH  activation GBF write address.
- GBFACT_DatWr  out  DATA_WIDTH  packed nonzero value.

Behaviour:
- Reset: rst_n asynchronous, active-low; clock clk, all flops on the rising edge.
  - At reset: state=IDLE, every EnWr=0, every AddrWr=0, every DatWr=0, CMPACT_Fnh=0.
  - CMPACT_RdyAct is combinational: (state==IDLE) && !CMPACT_Clr. It is therefore 1 after reset when Clr=0.
- State machine IDLE -> WRHDR -> WRDAT -> DONE -> IDLE.
  - IDLE: on Val&&Rdy, latch the block. Compute the registered mask, where mask[i] = (element i != 0), and the count = popcount(mask). Go to WRHDR.
  - WRHDR: if !GBFFLGACT_Full && !GBFVNACT_Full, write in the same cycle:
    - flag GBF: EnWr=1, DatWr=mask, at the current flag address;
    - valid-num GBF: EnWr=1, DatWr=count, at the current valid-num address.
    - Both addresses then increment.
    - Go to WRDAT if count!=0, otherwise go to DONE.
    - Otherwise hold, with both EnWr=0.
  - WRDAT: each cycle with !GBFACT_Full:
    - select the lowest set bit k of the remaining mask;
    - write element k (EnWr=1, DatWr=element k) at the current activation address;
    - clear bit k and increment the address.
    - When the last set bit is written, go to DONE.
    - If GBFACT_Full: EnWr=0, and state, mask and address hold.
  - DONE: CMPACT_Fnh=1 for exactly one cycle, then go to IDLE.
- Latency with no Full: accept at cycle t, header write at t+1, data writes at t+2..t+1+count, Fnh at t+2+count, next accept possible at t+3+count.
- Write-port outputs are registered or decoded from registered state. DatWr is don't-care when EnWr=0, but must be stable.
- Addresses wrap modulo 2^ADDR_WIDTH with no error flag. Overflow avoidance belongs to the controller.
- CMPACT_Clr:
  - honoured only in IDLE: all three addresses go to 0 on the next edge;
  - takes priority over Val in the same cycle, because Rdy=0 then;
  - ignored in WRHDR, WRDAT and DONE.
- A full block (count=BLOCK_DEPTH) produces 32 data writes, with VN=32 (6 bits).
- Val is ignored outside IDLE. The block input needs to be stable only in the accept cycle.
- Reset mid-block: the partial block is abandoned and addresses return to 0. Already-written entries are not retracted.

Decomposition:
- Shared package/include: DATA_WIDTH, BLOCK_DEPTH, GBFACT_ADDRWIDTH, VN width (clog2 macro), and the state encoding constants.
- One sub-module, act_lsb_scan, which is combinational: input is the BLOCK_DEPTH mask. Outputs are:
  - the one-hot lowest set bit,
  - its index, clog2(BLOCK_DEPTH) bits,
  - a "last" flag, true when exactly one bit is set.
- The popcount lives in the top level.

Test Plan:
- Block with elements 3=0x11, 7=0x22, 31=0x33, rest 0, all Full=0 ->
  - flag 0x80000088 written at flag addr 0, VN=3 at VN addr 0;
  - act writes 0x11, 0x22, 0x33 at addrs 0, 1, 2 on consecutive cycles;
  - Fnh 5 cycles after accept.
- All-zero block -> flag 0x00000000 and VN=0 written, no GBFACT_EnWr, Fnh 2 cycles after accept; a second block then starts its act writes at addr 0.
- All-nonzero block (element i = i+1) -> VN=32, 32 act writes 0x01..0x20 at addrs 0..31, Fnh 34 cycles after accept.
- GBFACT_Full high for 4 cycles mid-WRDAT, and GBFFLGACT_Full high 2 cycles in WRHDR -> no writes while Full, no data lost or duplicated, Fnh delayed by exactly 6 cycles.
- Write 3 blocks, then Clr in IDLE with Val high in the same cycle -> Rdy=0 that cycle, next block writes at addr 0 in all GBFs. Also set act addr=4094 with a block of count 4 -> act addrs 4094, 4095, 0, 1.
- rst_n asserted during WRDAT -> all outputs 0 immediately, state IDLE, Rdy=1 after release, the next block writes at addr 0.
